pack_i64_stream: RTL and testbench
==================================

Name: pack_i64_stream

Overview:
- Signed LEB128 encoder. It is the transmit-side counterpart of the combinational LEB128 unpackers.
- Accepts one 64-bit two's-complement value per handshake and serialises it into a byte stream, 1 to 10 bytes, least-significant group first.
- Sits between the value-producing datapath and the byte-oriented output buffer. Both sides use valid/ready.
- A parameter selects unsigned (u64) encoding, so the same block also serves as the u64 packer.

Parameters:
- SIGNED, 1, 1 = signed LEB128 (i64); 0 = unsigned LEB128 (u64).

Ports:
- clk        input   1   clock; all state updates on its rising edge
- rst        input   1   synchronous, active-high reset
- in_valid   input   1   in_data is valid
- in_ready   output  1   block can accept a new value
- in_data    input   64  value to encode (two's complement when SIGNED=1)
- out_valid  output  1   out_data is a valid encoded byte
- out_ready  input   1   downstream accepts out_data this cycle
- out_data   output  8   encoded byte; bit7 = continuation (glue) bit
- out_last   output  1   current byte is the final byte of the value (out_data[7]==0)
- out_len    output  4   total byte count of the value, 1..10; valid when out_valid && out_last

Behaviour:
- Reset (rst=1 at clock edge):
  - state := IDLE; out_valid=0, out_last=0, out_data=0, out_len=0; internal shift register and byte counter cleared.
  - in_ready=1 in the cycle after reset.
  - Reset mid-value drops the remaining bytes, with no further out_valid.
- States: IDLE, EMIT.
- in_ready = (state==IDLE). Back-to-back acceptance during the final byte is not supported.
- IDLE → EMIT:
  - Occurs on in_valid && in_ready. Latches in_data into a 64-bit residual register R; byte counter cnt := 0.
  - out_valid rises the next cycle. Acceptance-to-first-byte latency is 1 cycle.
- In EMIT, combinational from R and cnt:
  - grp = R[6:0].
  - nxt = R >>> 7 (arithmetic) when SIGNED=1; R >> 7 (logical) when SIGNED=0.
  - done (SIGNED=1) = (nxt==0 && grp[6]==0) || (nxt==all-ones && grp[6]==1).
  - done (SIGNED=0) = (nxt==0).
  - done is forced to 1 when cnt==9. This is the safety bound; the encoding rule already terminates by byte 10 for every 64-bit input.
  - out_data = {~done, grp}; out_last = done; out_len = cnt+1.
- Output handshake:
  - Transfer occurs when out_valid && out_ready.
  - If out_valid && !out_ready: out_data, out_last, out_len and R hold stable. out_valid is never withdrawn before transfer.
  - On transfer with !done: R := nxt, cnt := cnt+1, stay in EMIT.
  - On transfer with done: state := IDLE, out_valid := 0 next cycle, in_ready := 1 next cycle.
- Throughput:
  - 1 byte/cycle while out_ready is held high.
  - One value every (len+1) cycles: len bytes plus 1 IDLE cycle.
- Width: cnt is 4 bits, 0..9. out_len is 1..10 and never 0 while out_valid.
- in_valid while in EMIT is ignored; in_data is not sampled.
- in_valid and rst in the same cycle: reset wins and the value is not accepted.

Test Plan:
- SIGNED=1, single-byte values, out_ready=1:
  - 0 → 0x00, last, len=1.
  - −1 → 0x7F, len=1.
  - 63 → 0x3F.
  - −64 → 0x40.
- SIGNED=1, boundary and multi-byte values:
  - 64 → 0xC0,0x00 (len=2).
  - −65 → 0xBF,0x7F.
  - 624485 → 0xE5,0x8E,0x26 (len=3).
  - −123456 → 0xC0,0xBB,0x78 (len=3).
- SIGNED=1, extreme values:
  - INT64_MIN → nine 0x80 bytes then 0x7F, len=10.
  - INT64_MAX → nine 0xFF bytes then 0x00, len=10.
- SIGNED=0, extreme values:
  - 2^64−1 → nine 0xFF bytes then 0x01, len=10.
  - 128 → 0x80,0x01.
- Backpressure:
  - Encode −123456 with out_ready toggled randomly.
  - out_data and out_last are stable while stalled; byte sequence unchanged.
  - in_ready stays 0 until the cycle after the last byte transfers.
- Reset mid-value:
  - Assert rst after the 2nd byte of INT64_MIN.
  - Next cycle: out_valid=0, in_ready=1.
  - A following value 5 emits 0x05, len=1, with no leftover bytes.

Source files
------------

// File: rtl/pack_i64_stream.sv
// LEB128 byte-stream encoder for one 64-bit value per input handshake.
// Emits 1..10 bytes, least-significant 7-bit group first, over valid/ready.
// SIGNED=1 gives signed LEB128 (i64); SIGNED=0 gives unsigned LEB128 (u64).
module pack_i64_stream #(
   parameter bit SIGNED = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [63:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  out_data,
   output logic        out_last,
   output logic [3:0]  out_len
);

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] r_q, r_d;      // residual value still to be emitted
   logic [3:0]  cnt_q, cnt_d;  // index of the byte currently presented
   logic [6:0]  grp;
   logic [63:0] nxt;
   logic        done;

   // Current 7-bit group, the residual after it, and whether it is the final byte
   always_comb begin
      grp = r_q[6:0];
      if (SIGNED) begin
         nxt  = $unsigned($signed(r_q) >>> 7);
         // The remaining bits must all equal the sign bit of the group just sent
         done = ((nxt == '0) && !grp[6]) || ((nxt == '1) && grp[6]);
      end else begin
         nxt  = r_q >> 7;
         done = (nxt == '0);
      end
      // Ten groups cover all 64 bits; this bound can never cut a value short
      if (cnt_q == 4'd9) begin
         done = 1'b1;
      end
   end

   // Next-state and output decode; outputs are all zero outside EMIT
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves
      // a variable unassigned, which would otherwise infer a latch.
      state_d   = state_q;
      r_d       = r_q;
      cnt_d     = cnt_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_data  = '0;
      out_last  = 1'b0;
      out_len   = '0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               state_d = EMIT;
               r_d     = in_data;
               cnt_d   = '0;
            end
         end
         EMIT: begin
            out_valid = 1'b1;
            out_data  = {~done, grp};
            out_last  = done;
            out_len   = cnt_q + 4'd1;
            // A stalled byte holds R and cnt, so every output stays stable
            if (out_ready) begin
               if (done) begin
                  state_d = IDLE;
               end else begin
                  r_d   = nxt;
                  cnt_d = cnt_q + 4'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, residual and byte-counter registers with synchronous reset
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         state_q <= IDLE;
         r_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         r_q     <= r_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_pack_i64_stream.sv
// Directed bench for pack_i64_stream: one signed and one unsigned instance,
// expected bytes queued at stimulus time and compared as each byte transfers.
module tb_pack_i64_stream;

   typedef struct {
      logic [7:0] data;
      logic       last;
      logic [3:0] len;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [63:0] in_data;
   logic        out_ready;
   logic        s_in_valid, u_in_valid;
   logic        s_in_ready, u_in_ready;
   logic        s_out_valid, u_out_valid;
   logic [7:0]  s_out_data, u_out_data;
   logic        s_out_last, u_out_last;
   logic [3:0]  s_out_len, u_out_len;

   // Observed signals of whichever instance is under test
   logic        sel;
   logic        o_in_ready, o_out_valid, o_out_last;
   logic [7:0]  o_out_data;
   logic [3:0]  o_out_len;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   pack_i64_stream #(.SIGNED(1'b1)) dut_s (
      .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
      .out_data(s_out_data), .out_last(s_out_last), .out_len(s_out_len)
   );

   pack_i64_stream #(.SIGNED(1'b0)) dut_u (
      .clk(clk), .rst(rst), .in_valid(u_in_valid), .in_ready(u_in_ready),
      .in_data(in_data), .out_valid(u_out_valid), .out_ready(out_ready),
      .out_data(u_out_data), .out_last(u_out_last), .out_len(u_out_len)
   );

   assign o_in_ready  = sel ? u_in_ready  : s_in_ready;
   assign o_out_valid = sel ? u_out_valid : s_out_valid;
   assign o_out_data  = sel ? u_out_data  : s_out_data;
   assign o_out_last  = sel ? u_out_last  : s_out_last;
   assign o_out_len   = sel ? u_out_len   : s_out_len;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_valid(input bit use_u, input bit v);
      s_in_valid = !use_u && v;
      u_in_valid = use_u && v;
   endtask

   // Queue n expected bytes; bytes[7:0] is the first byte on the wire
   task automatic push_exp(input int n, input logic [79:0] bytes, input bit has_last);
      for (int i = 0; i < n; i++) begin
         exp_q.push_back('{data: bytes[i*8 +: 8],
                           last: has_last && (i == n - 1),
                           len:  4'(i + 1)});
      end
   endtask

   // Compare the presented byte against the queue head and pop it
   task automatic take_byte();
      exp_t e;
      e = exp_q.pop_front();
      check("out_data", o_out_data, e.data);
      check("out_last", o_out_last, e.last);
      check("out_len",  o_out_len,  e.len);
   endtask

   // Drain the queue from the selected instance, called at a negedge in EMIT
   task automatic run_out(input bit bp, input bit junk);
      int         cycles  = 0;
      bit         stalled = 1'b0;
      logic [7:0] pd      = '0;
      logic       pl      = 1'b0;
      bit         is_last;
      while (exp_q.size() > 0 && cycles < 200) begin
         if (stalled) begin
            check("stall_data", o_out_data, pd);
            check("stall_last", o_out_last, pl);
         end
         check("out_valid_busy", o_out_valid, 1);
         check("in_ready_busy",  o_in_ready,  0);
         out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (o_out_valid && out_ready) begin
            is_last = exp_q[0].last;
            take_byte();
            stalled = 1'b0;
            if (is_last || !junk) set_valid(sel, 1'b0);
         end else begin
            stalled = 1'b1;
            pd      = o_out_data;
            pl      = o_out_last;
         end
         @(negedge clk);
         cycles++;
      end
      if (exp_q.size() != 0) begin
         check("timeout_bytes_left", 64'(exp_q.size()), 0);
         exp_q.delete();
      end
      set_valid(sel, 1'b0);
      out_ready = 1'b1;
   endtask

   // Encode one value; junk=1 keeps in_valid high with other data during EMIT
   task automatic encode(input bit use_u, input logic [63:0] value, input int n,
                         input logic [79:0] bytes, input bit bp, input bit junk);
      push_exp(n, bytes, 1'b1);
      @(negedge clk);
      sel = use_u;
      check("in_ready_idle", o_in_ready, 1);
      in_data   = value;
      out_ready = 1'b1;
      set_valid(use_u, 1'b1);
      @(negedge clk);
      set_valid(use_u, junk);
      if (junk) in_data = 64'h5A5A_5A5A_5A5A_5A5A;
      run_out(bp, junk);
      check("out_valid_done", o_out_valid, 0);
      check("in_ready_done",  o_in_ready,  1);
   endtask

   initial begin
      rst       = 1'b1;
      in_data   = '0;
      out_ready = 1'b1;
      sel       = 1'b0;
      set_valid(1'b0, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state of both instances
      check("rst_s_out_valid", s_out_valid, 0);
      check("rst_s_out_data",  s_out_data,  0);
      check("rst_s_out_last",  s_out_last,  0);
      check("rst_s_out_len",   s_out_len,   0);
      check("rst_s_in_ready",  s_in_ready,  1);
      check("rst_u_out_valid", u_out_valid, 0);
      check("rst_u_in_ready",  u_in_ready,  1);

      // Signed single-byte values
      encode(1'b0, 64'd0,         1, 80'h00, 1'b0, 1'b0);
      encode(1'b0, -64'sd1,       1, 80'h7F, 1'b0, 1'b0);
      encode(1'b0, 64'd63,        1, 80'h3F, 1'b0, 1'b0);
      encode(1'b0, -64'sd64,      1, 80'h40, 1'b0, 1'b0);

      // Signed boundary and multi-byte values
      encode(1'b0, 64'd64,        2, 80'h00C0,   1'b0, 1'b0);
      encode(1'b0, -64'sd65,      2, 80'h7FBF,   1'b0, 1'b0);
      encode(1'b0, 64'd624485,    3, 80'h268EE5, 1'b0, 1'b0);
      encode(1'b0, -64'sd123456,  3, 80'h78BBC0, 1'b0, 1'b0);

      // Signed extremes
      encode(1'b0, 64'h8000_0000_0000_0000, 10, {8'h7F, {9{8'h80}}}, 1'b0, 1'b0);
      encode(1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 10, {8'h00, {9{8'hFF}}}, 1'b0, 1'b0);

      // Unsigned extremes
      encode(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 10, {8'h01, {9{8'hFF}}}, 1'b0, 1'b0);
      encode(1'b1, 64'd128,       2, 80'h0180, 1'b0, 1'b0);

      // Backpressure with in_valid asserted (and ignored) during EMIT
      encode(1'b0, -64'sd123456,  3, 80'h78BBC0, 1'b1, 1'b1);
      encode(1'b0, 64'h8000_0000_0000_0000, 10, {8'h7F, {9{8'h80}}}, 1'b1, 1'b0);

      // Reset after the second byte of INT64_MIN, with in_valid during reset
      push_exp(2, 80'h8080, 1'b0);
      @(negedge clk);
      sel       = 1'b0;
      in_data   = 64'h8000_0000_0000_0000;
      out_ready = 1'b1;
      set_valid(1'b0, 1'b1);
      @(negedge clk);
      set_valid(1'b0, 1'b0);
      take_byte();
      @(negedge clk);
      take_byte();
      @(negedge clk);
      rst     = 1'b1;
      in_data = 64'd7;
      set_valid(1'b0, 1'b1);
      @(negedge clk);
      rst = 1'b0;
      set_valid(1'b0, 1'b0);
      check("midrst_out_valid", o_out_valid, 0);
      check("midrst_in_ready",  o_in_ready,  1);
      check("midrst_out_data",  o_out_data,  0);
      @(negedge clk);
      check("midrst_no_accept", o_out_valid, 0);
      encode(1'b0, 64'd5, 1, 80'h05, 1'b0, 1'b0);
      @(negedge clk);
      check("post_no_leftover", o_out_valid, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
